// File: rtl/round_pkg.sv
// Shared encodings for the round sequencer: FSM states, countdown width and round durations.
package round_pkg;

    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] DUR_0 = CNT_W'(10);
    localparam logic [CNT_W-1:0] DUR_1 = CNT_W'(20);
    localparam logic [CNT_W-1:0] DUR_2 = CNT_W'(30);
    localparam logic [CNT_W-1:0] DUR_3 = CNT_W'(60);

    function automatic logic [CNT_W-1:0] duration_map(input logic [1:0] sel);
        logic [CNT_W-1:0] dur;
        case (sel)
            2'd0:    dur = DUR_0;
            2'd1:    dur = DUR_1;
            2'd2:    dur = DUR_2;
            default: dur = DUR_3;
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int unsigned CLK_HZ = 65_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(CLK_HZ - 1);

    logic [PS_W-1:0] count;

    // Count holds whenever not enabled, so the phase freezes outside RUN.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + PS_W'(1);
        end
    end

    assign tick_c = enable && (count == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Round control around the countdown timer: starts the timer, paces it, and reports each round's outcome.
module round_sequencer
    import round_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 65_000_000,
    parameter int unsigned ROUND_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic               abort,
    input  logic               answer,
    input  logic [1:0]         duration_sel,
    input  logic [CNT_W-1:0]   countdown,
    input  logic               time_expired,
    output logic               start,
    output logic [CNT_W-1:0]   time_parameter,
    output logic               one_hz_enable,
    output logic [2:0]         state,
    output logic               round_over,
    output logic               answered_in_time,
    output logic [CNT_W-1:0]   remaining,
    output logic [ROUND_W-1:0] rounds_played
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   time_parameter_d;
    logic               round_over_d;
    logic               answered_in_time_d;
    logic [CNT_W-1:0]   remaining_d;
    logic [ROUND_W-1:0] rounds_played_d;
    logic [ROUND_W-1:0] rounds_inc;
    logic               tick;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == LOAD),
        .enable  (state_q == RUN),
        .tick_c  (tick)
    );

    assign rounds_inc = (rounds_played == '1) ? rounds_played : rounds_played + ROUND_W'(1);

    // Next-state and next-output decode; abort overrides every other request.
    always_comb begin
        state_d            = state_q;
        time_parameter_d   = time_parameter;
        round_over_d       = 1'b0;
        answered_in_time_d = answered_in_time;
        remaining_d        = remaining;
        rounds_played_d    = rounds_played;

        if (abort) begin
            state_d            = IDLE;
            answered_in_time_d = 1'b0;
            remaining_d        = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_d            = LOAD;
                        time_parameter_d   = duration_map(duration_sel);
                        answered_in_time_d = 1'b0;
                        remaining_d        = '0;
                    end
                end
                LOAD: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (answer) begin
                        state_d            = DONE;
                        round_over_d       = 1'b1;
                        answered_in_time_d = 1'b1;
                        remaining_d        = countdown;
                        rounds_played_d    = rounds_inc;
                    end else if (time_expired) begin
                        state_d            = DONE;
                        round_over_d       = 1'b1;
                        answered_in_time_d = 1'b0;
                        remaining_d        = '0;
                        rounds_played_d    = rounds_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            time_parameter   <= '0;
            round_over       <= 1'b0;
            answered_in_time <= 1'b0;
            remaining        <= '0;
            rounds_played    <= '0;
        end else begin
            state_q          <= state_d;
            time_parameter   <= time_parameter_d;
            round_over       <= round_over_d;
            answered_in_time <= answered_in_time_d;
            remaining        <= remaining_d;
            rounds_played    <= rounds_played_d;
        end
    end

    // Decoded strobes are suppressed in an abort cycle so the timer never sees a stray start or tick.
    assign start         = (state_q == LOAD) && !abort;
    assign one_hz_enable = tick && !abort;
    assign state         = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer with a behavioural countdown timer and a round-outcome scoreboard.
module tb_round_sequencer;
    import round_pkg::*;

    localparam int unsigned CLK_HZ  = 4;
    localparam int unsigned ROUND_W = 8;

    logic             clock = 1'b0;
    logic             reset_n, go, abort, answer;
    logic [1:0]       duration_sel;
    logic [5:0]       countdown;
    logic             time_expired;
    logic             start, one_hz_enable, round_over, answered_in_time;
    logic [5:0]       time_parameter, remaining;
    logic [2:0]       state;
    logic [7:0]       rounds_played;

    typedef struct {
        logic       ait;
        logic [5:0] rem;
        logic [7:0] rp;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   exp_rounds = 0;

    always #5 clock = ~clock;

    round_sequencer #(.CLK_HZ(CLK_HZ), .ROUND_W(ROUND_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .go               (go),
        .abort            (abort),
        .answer           (answer),
        .duration_sel     (duration_sel),
        .countdown        (countdown),
        .time_expired     (time_expired),
        .start            (start),
        .time_parameter   (time_parameter),
        .one_hz_enable    (one_hz_enable),
        .state            (state),
        .round_over       (round_over),
        .answered_in_time (answered_in_time),
        .remaining        (remaining),
        .rounds_played    (rounds_played)
    );

    // Countdown timer model: loads on start, decrements per tick, flags expiry as it reaches zero.
    always @(posedge clock) begin
        if (!reset_n) begin
            countdown    <= 6'd0;
            time_expired <= 1'b0;
        end else if (start) begin
            countdown    <= time_parameter;
            time_expired <= 1'b0;
        end else if (one_hz_enable && countdown != 6'd0) begin
            countdown <= countdown - 6'd1;
            if (countdown == 6'd1) time_expired <= 1'b1;
        end
    end

    // Scoreboard consumer: every round_over pulse must match the oldest expected outcome.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && round_over === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_round_over: got round_over=1 with rounds_played=%0d, required no pulse", rounds_played);
            end else begin
                e = sb.pop_front();
                if ({answered_in_time, remaining, rounds_played} !== {e.ait, e.rem, e.rp}) begin
                    mismatched++;
                    $display("FAIL sb_round_outcome: got ait=%0d rem=%0d rounds=%0d, required ait=%0d rem=%0d rounds=%0d",
                             answered_in_time, remaining, rounds_played, e.ait, e.rem, e.rp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic ait, input logic [5:0] rem);
        exp_t e;
        exp_rounds = (exp_rounds < 255) ? exp_rounds + 1 : 255;
        e.ait = ait;
        e.rem = rem;
        e.rp  = 8'(exp_rounds);
        sb.push_back(e);
    endtask

    task automatic start_round(input logic [1:0] sel);
        go           = 1'b1;
        duration_sel = sel;
        step();
        go = 1'b0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        int starts = 0;
        reset_n = 1'b0; go = 1'b0; abort = 1'b0; answer = 1'b0; duration_sel = 2'd0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        compared++;
        if ({state, start, one_hz_enable, round_over, answered_in_time} !== 7'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got state=%0d start=%0d tick=%0d ro=%0d ait=%0d, required all 0",
                     state, start, one_hz_enable, round_over, answered_in_time);
        end
        compared++;
        if ({time_parameter, remaining, rounds_played} !== 20'd0) begin
            mismatched++;
            $display("FAIL reset_data: got tp=%0d rem=%0d rounds=%0d, required 0 0 0", time_parameter, remaining, rounds_played);
        end
        for (int i = 0; i < 50; i++) begin
            if (one_hz_enable) ticks++;
            if (start) starts++;
            step();
        end
        compared++;
        if (ticks != 0 || starts != 0 || state !== 3'd0) begin
            mismatched++;
            $display("FAIL idle_quiet: got ticks=%0d starts=%0d state=%0d, required 0 0 0", ticks, starts, state);
        end
    endtask

    task automatic test_expiry();
        int cyc = 1, ticks = 0, first = 0, last = 0, bad_gap = 0;
        push_exp(1'b0, 6'd0);
        start_round(2'd0);
        compared++;
        if (state !== 3'd1 || start !== 1'b1 || time_parameter !== 6'd10) begin
            mismatched++;
            $display("FAIL load_sel0: got state=%0d start=%0d tp=%0d, required 1 1 10", state, start, time_parameter);
        end
        step();
        compared++;
        if (state !== 3'd2 || start !== 1'b0) begin
            mismatched++;
            $display("FAIL start_one_cycle: got state=%0d start=%0d, required 2 0", state, start);
        end
        while (state === 3'd2 && cyc < 200) begin
            if (one_hz_enable) begin
                ticks++;
                if (first == 0) first = cyc;
                else if (cyc - last != 4) bad_gap++;
                last = cyc;
            end
            step();
            cyc++;
        end
        compared++;
        if (state !== 3'd3 || ticks != 10 || first != 4 || bad_gap != 0) begin
            mismatched++;
            $display("FAIL tick_cadence: got state=%0d ticks=%0d first=%0d bad_gaps=%0d, required 3 10 4 0",
                     state, ticks, first, bad_gap);
        end
        compared++;
        if (round_over !== 1'b1 || countdown !== 6'd0) begin
            mismatched++;
            $display("FAIL expiry_end: got round_over=%0d countdown=%0d, required 1 0", round_over, countdown);
        end
        step();
        compared++;
        if (round_over !== 1'b0 || one_hz_enable !== 1'b0 || state !== 3'd3) begin
            mismatched++;
            $display("FAIL done_hold: got ro=%0d tick=%0d state=%0d, required 0 0 3", round_over, one_hz_enable, state);
        end
    endtask

    task automatic test_answer();
        int ticks = 0, cyc = 0, late = 0;
        start_round(2'd1);
        compared++;
        if (time_parameter !== 6'd20) begin
            mismatched++;
            $display("FAIL load_sel1: got tp=%0d, required 20", time_parameter);
        end
        step();
        while (ticks < 3 && cyc < 100) begin
            if (one_hz_enable) ticks++;
            step();
            cyc++;
        end
        compared++;
        if (countdown !== 6'd17 || state !== 3'd2) begin
            mismatched++;
            $display("FAIL three_ticks: got countdown=%0d state=%0d, required 17 2", countdown, state);
        end
        answer = 1'b1;
        push_exp(1'b1, 6'd17);
        step();
        answer = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (one_hz_enable) late++;
            step();
        end
        compared++;
        if (state !== 3'd3 || late != 0 || countdown !== 6'd17 || remaining !== 6'd17 || answered_in_time !== 1'b1) begin
            mismatched++;
            $display("FAIL answer_freeze: got state=%0d ticks=%0d countdown=%0d rem=%0d ait=%0d, required 3 0 17 17 1",
                     state, late, countdown, remaining, answered_in_time);
        end
    endtask

    task automatic test_simultaneous();
        int cyc = 0;
        start_round(2'd0);
        compared++;
        if (answered_in_time !== 1'b0 || remaining !== 6'd0) begin
            mismatched++;
            $display("FAIL go_clears_done: got ait=%0d rem=%0d, required 0 0", answered_in_time, remaining);
        end
        step();
        while (time_expired !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        compared++;
        if (time_expired !== 1'b1 || state !== 3'd2) begin
            mismatched++;
            $display("FAIL expire_seen_in_run: got expired=%0d state=%0d, required 1 2", time_expired, state);
        end
        answer = 1'b1;
        push_exp(1'b1, 6'd0);
        step();
        answer = 1'b0;
        compared++;
        if (state !== 3'd3 || answered_in_time !== 1'b1 || remaining !== 6'd0) begin
            mismatched++;
            $display("FAIL answer_wins: got state=%0d ait=%0d rem=%0d, required 3 1 0", state, answered_in_time, remaining);
        end
    endtask

    task automatic test_abort();
        int ticks = 0, cyc = 0;
        start_round(2'd2);
        step();
        while (ticks < 2 && cyc < 100) begin
            if (one_hz_enable) ticks++;
            step();
            cyc++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        compared++;
        if (state !== 3'd0 || answered_in_time !== 1'b0 || remaining !== 6'd0 || rounds_played !== 8'(exp_rounds)) begin
            mismatched++;
            $display("FAIL abort_idle: got state=%0d ait=%0d rem=%0d rounds=%0d, required 0 0 0 %0d",
                     state, answered_in_time, remaining, rounds_played, exp_rounds);
        end
        go = 1'b1; abort = 1'b1; duration_sel = 2'd3;
        step();
        go = 1'b0; abort = 1'b0;
        compared++;
        if (state !== 3'd0) begin
            mismatched++;
            $display("FAIL abort_over_go: got state=%0d, required 0", state);
        end
        push_exp(1'b0, 6'd0);
        start_round(2'd3);
        compared++;
        if (time_parameter !== 6'd60 || start !== 1'b1) begin
            mismatched++;
            $display("FAIL restart_sel3: got tp=%0d start=%0d, required 60 1", time_parameter, start);
        end
        cyc = 0;
        while (state !== 3'd3 && cyc < 400) begin
            step();
            cyc++;
        end
        compared++;
        if (state !== 3'd3) begin
            mismatched++;
            $display("FAIL sel3_timeout: got state=%0d after %0d cycles, required 3", state, cyc);
        end
    endtask

    task automatic test_saturation();
        int n;
        n = 255 - exp_rounds;
        for (int i = 0; i < n; i++) begin
            start_round(2'd0);
            step();
            answer = 1'b1;
            push_exp(1'b1, 6'd10);
            step();
            answer = 1'b0;
        end
        compared++;
        if (rounds_played !== 8'd255) begin
            mismatched++;
            $display("FAIL reach_255: got rounds=%0d, required 255", rounds_played);
        end
        start_round(2'd0);
        step();
        answer = 1'b1;
        push_exp(1'b1, 6'd10);
        step();
        answer = 1'b0;
        compared++;
        if (rounds_played !== 8'd255 || state !== 3'd3) begin
            mismatched++;
            $display("FAIL saturate: got rounds=%0d state=%0d, required 255 3", rounds_played, state);
        end
        start_round(2'd1);
        step();
        step();
        compared++;
        if (state !== 3'd2) begin
            mismatched++;
            $display("FAIL pre_reset_run: got state=%0d, required 2", state);
        end
        reset_n = 1'b0;
        step();
        compared++;
        if ({state, start, one_hz_enable, round_over, answered_in_time, time_parameter, remaining, rounds_played} !== 27'd0) begin
            mismatched++;
            $display("FAIL midrun_reset: got state=%0d tp=%0d rem=%0d rounds=%0d ro=%0d ait=%0d, required all 0",
                     state, time_parameter, remaining, rounds_played, round_over, answered_in_time);
        end
        reset_n    = 1'b1;
        exp_rounds = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_answer();
        test_simultaneous();
        test_abort();
        test_saturation();
        repeat (3) step();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d pending rounds, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
